// File: rtl/rx_skp_write_ctrl_if.sv
// Bus between the elastic-buffer front end and the SKP write controller.
// Handshake: rx_data is meaningful only in a cycle where elstc_buff_en=1; there
// is no back-pressure, and write_en qualifies that same cycle's symbol for the
// elastic buffer. rmv_done/rmv_abort are one-cycle registered pulses.
interface rx_skp_write_ctrl_if #(
  parameter int BUFFER_WIDTH = 13,
  parameter int TOT_W        = 16
);
  logic [BUFFER_WIDTH-1:0] rx_data;
  logic                    elstc_buff_en;
  logic                    SKP_remv_rqst;
  logic                    write_en;
  logic                    rmv_done;
  logic                    rmv_abort;
  logic [5:0]              deleted_count;
  logic [TOT_W-1:0]        total_deleted;
  logic [1:0]              dbg_state;

  modport master (
    output rx_data, elstc_buff_en, SKP_remv_rqst,
    input  write_en, rmv_done, rmv_abort, deleted_count, total_deleted, dbg_state
  );

  modport slave (
    input  rx_data, elstc_buff_en, SKP_remv_rqst,
    output write_en, rmv_done, rmv_abort, deleted_count, total_deleted, dbg_state
  );
endinterface

// File: rtl/rx_skp_write_ctrl.sv
// SKP removal write controller: drops whole groups of GRAN SKP symbols from an
// SKP ordered set while the fill monitor requests it, up to MAX_GROUPS groups
// per ordered set. Dropped symbols simply get write_en=0.
module rx_skp_write_ctrl #(
  parameter int                BUFFER_WIDTH = 13,
  parameter int                SYM_W        = 9,
  parameter logic [SYM_W-1:0]  SKP_SYM      = 9'h199,
  parameter int                GRAN         = 4,
  parameter int                MAX_GROUPS   = 2,
  parameter int                TOT_W        = 16
) (
  input logic                  rx_clk,
  input logic                  rx_rst,
  rx_skp_write_ctrl_if.slave   bus
);
  localparam int IDX_W = BUFFER_WIDTH - SYM_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEL  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [3:0]       sym_cnt, sym_cnt_n, cnt_inc;
  logic [2:0]       groups, groups_n;
  logic [IDX_W-1:0] idx;
  logic             is_skp, is_end;
  logic             drop, done_n, abort_n, to_idle;
  logic [31:0]      gap_idx;
  logic             done_q, abort_q;
  logic [5:0]       del_cnt;
  logic [TOT_W-1:0] tot_cnt;

  assign idx     = bus.rx_data[BUFFER_WIDTH-1:SYM_W];
  assign is_skp  = (bus.rx_data[SYM_W-1:0] == SKP_SYM);
  assign is_end  = (idx == {IDX_W{1'b1}});
  // A further group may only start exactly where the previous ones ended.
  assign gap_idx = 32'(groups) * 32'(GRAN);

  // Next-state decode: decide drop/keep for the current symbol and group bookkeeping.
  always_comb begin
    state_n   = state;
    sym_cnt_n = sym_cnt;
    groups_n  = groups;
    cnt_inc   = 4'd0;
    drop      = 1'b0;
    done_n    = 1'b0;
    abort_n   = 1'b0;
    to_idle   = 1'b0;
    if (bus.elstc_buff_en) begin
      case (state)
        IDLE: begin
          if (bus.SKP_remv_rqst && is_skp && idx == '0) begin
            drop    = 1'b1;
            cnt_inc = 4'd1;
          end
        end
        DEL: begin
          // The request is deliberately ignored here: a started group runs to completion.
          if (is_skp && !is_end) begin
            drop    = 1'b1;
            cnt_inc = sym_cnt + 4'd1;
          end else begin
            abort_n = 1'b1;
            to_idle = 1'b1;
          end
        end
        GAP: begin
          if (bus.SKP_remv_rqst && is_skp && !is_end &&
              groups < 3'(MAX_GROUPS) && 32'(idx) == gap_idx) begin
            drop    = 1'b1;
            cnt_inc = 4'd1;
          end else if (!is_skp || is_end) begin
            to_idle = 1'b1;
          end
        end
        default: to_idle = 1'b1;
      endcase
      if (drop) begin
        if (cnt_inc == 4'(GRAN)) begin
          groups_n  = groups + 3'd1;
          sym_cnt_n = 4'd0;
          done_n    = 1'b1;
          state_n   = GAP;
        end else begin
          sym_cnt_n = cnt_inc;
          state_n   = DEL;
        end
      end
      if (to_idle) begin
        state_n   = IDLE;
        sym_cnt_n = 4'd0;
        groups_n  = 3'd0;
      end
    end
  end

  // State, counters and registered status pulses.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state   <= IDLE;
      sym_cnt <= 4'd0;
      groups  <= 3'd0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      del_cnt <= 6'd0;
      tot_cnt <= '0;
    end else begin
      state   <= state_n;
      sym_cnt <= sym_cnt_n;
      groups  <= groups_n;
      done_q  <= done_n;
      abort_q <= abort_n;
      if (to_idle) begin
        del_cnt <= 6'd0;
      end else if (drop) begin
        del_cnt <= del_cnt + 6'd1;
      end
      if (drop && tot_cnt != {TOT_W{1'b1}}) begin
        tot_cnt <= tot_cnt + TOT_W'(1);
      end
    end
  end

  // While reset is held nothing is dropped, so the strobe follows the enable.
  assign bus.write_en      = bus.elstc_buff_en & (rx_rst | ~drop);
  assign bus.rmv_done      = done_q;
  assign bus.rmv_abort     = abort_q;
  assign bus.deleted_count = del_cnt;
  assign bus.total_deleted = tot_cnt;
  assign bus.dbg_state     = state;
endmodule
